// File: rtl/serial_add_sched_pkg.sv
// rtl/serial_add_sched_pkg.sv - shared state type and requester count for the serial add scheduler
package serial_add_sched_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_with_vld.sv
// rtl/serial_adder_with_vld.sv - bit-serial full adder whose carry clears on the last bit
module serial_adder_with_vld (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic a,
    input  logic b,
    input  logic last,
    output logic sum
);

    logic carry_q;
    logic carry_d;

    assign sum = a ^ b ^ carry_q;

    // Carry-out of the final bit is dropped so the next operation starts from zero.
    always_comb begin
        carry_d = carry_q;
        if (vld) begin
            carry_d = last ? 1'b0 : ((a & b) | (a & carry_q) | (b & carry_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serial_add_scheduler.sv
// rtl/serial_add_scheduler.sv - round-robin two-requester front end for an LSB-first serial adder
module serial_add_scheduler
    import serial_add_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_vld,
    output logic [NUM_REQ-1:0]              req_rdy,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
    output logic                            res_vld,
    input  logic                            res_rdy,
    output logic                            res_id,
    output logic [WIDTH-1:0]                res_sum
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               gid;
    logic               add_vld;
    logic               add_a;
    logic               add_b;
    logic               add_last;
    logic               add_sum;

    serial_adder_with_vld u_adder (
        .clk  (clk),
        .rst  (~rst),
        .vld  (add_vld),
        .a    (add_a),
        .b    (add_b),
        .last (add_last),
        .sum  (add_sum)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        req_rdy  = '0;
        add_vld  = 1'b0;
        add_a    = 1'b0;
        add_b    = 1'b0;
        add_last = 1'b0;
        gid      = (req_vld == 2'b11) ? ptr_q : req_vld[1];

        case (state_q)
            IDLE: begin
                if (|req_vld) begin
                    req_rdy[gid] = 1'b1;
                    id_d         = gid;
                    ptr_d        = ~gid;
                    a_d          = req_a[gid];
                    b_d          = req_b[gid];
                    cnt_d        = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                add_vld  = 1'b1;
                add_a    = a_q[0];
                add_b    = b_q[0];
                add_last = (cnt_q == LAST_BIT);
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                // Sum bits enter at the top and walk down, so bit 0 lands in place after WIDTH shifts.
                sum_d    = {add_sum, sum_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (add_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake and adder strobes stay quiet for the whole reset cycle.
        if (!rst) begin
            req_rdy  = '0;
            add_vld  = 1'b0;
            add_last = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_vld = (state_q == DONE);
    assign res_id  = id_q;
    assign res_sum = sum_q;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// tb/tb_serial_add_scheduler.sv - self-checking bench for serial_add_scheduler
module tb_serial_add_scheduler;

    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic [1:0]       req_vld;
    logic [1:0]       req_rdy;
    logic [1:0][W-1:0] req_a;
    logic [1:0][W-1:0] req_b;
    logic             res_vld;
    logic             res_rdy;
    logic             res_id;
    logic [W-1:0]     res_sum;

    int total;
    int passed;
    int cyc;

    serial_add_scheduler #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_a   (req_a),
        .req_b   (req_b),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res_id  (res_id),
        .res_sum (res_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference model: an operation granted at cycle T occupies T+1..T+W with the adder
    // strobed, then presents (A+B) mod 2^W until the consumer takes it.
    bit         m_armed = 0;
    bit         m_busy  = 0;
    bit         m_ptr   = 0;
    bit         m_id;
    int         m_t;
    logic [W-1:0] m_sum;

    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        logic       win;
        if (!rst) begin
            if (m_armed) begin
                chk("rst_req_rdy", req_rdy, 2'b00);
                chk("rst_add_vld", dut.u_adder.vld, 1'b0);
            end
            m_busy  = 0;
            m_ptr   = 0;
            m_armed = 1;
        end else if (m_armed) begin
            if (m_busy) begin
                m_t++;
                chk("busy_req_rdy", req_rdy, 2'b00);
                if (m_t <= W) begin
                    chk("shift_res_vld", res_vld, 1'b0);
                    chk("shift_add_vld", dut.u_adder.vld, 1'b1);
                    chk("shift_add_last", dut.u_adder.last, (m_t == W));
                end else begin
                    chk("done_res_vld", res_vld, 1'b1);
                    chk("done_res_sum", res_sum, m_sum);
                    chk("done_res_id", res_id, m_id);
                    chk("done_add_vld", dut.u_adder.vld, 1'b0);
                    if (res_rdy) m_busy = 0;
                end
            end else begin
                exp_rdy = 2'b00;
                chk("idle_res_vld", res_vld, 1'b0);
                chk("idle_add_vld", dut.u_adder.vld, 1'b0);
                if (req_vld != 2'b00) begin
                    win          = (req_vld == 2'b11) ? m_ptr : req_vld[1];
                    exp_rdy[win] = 1'b1;
                    m_ptr        = ~win;
                    m_id         = win;
                    m_sum        = req_a[win] + req_b[win];
                    m_busy       = 1;
                    m_t          = 0;
                end
                chk("idle_req_rdy", req_rdy, exp_rdy);
            end
        end
    end

    // Adder strobe run length: WIDTH consecutive cycles, last only on the final one.
    int run = 0;
    always @(negedge clk) begin
        if (!rst) begin
            run = 0;
        end else if (dut.u_adder.vld) begin
            run++;
            if (dut.u_adder.last) chk("last_position", run, W);
        end else begin
            if (run != 0) chk("vld_run_length", run, W);
            run = 0;
        end
    end

    task automatic wait_grant(input int idx, output int t0);
        bit ok = 0;
        t0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_rdy[idx]) begin
                ok = 1;
                t0 = cyc;
                break;
            end
        end
        chk("grant_seen", ok, 1'b1);
    endtask

    task automatic wait_result(output int t1);
        bit ok = 0;
        t1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_vld) begin
                ok = 1;
                t1 = cyc;
                break;
            end
        end
        chk("result_seen", ok, 1'b1);
    endtask

    task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input logic eid);
        int t0, t1;
        req_a[idx]   = a;
        req_b[idx]   = b;
        req_vld[idx] = 1'b1;
        wait_grant(idx, t0);
        @(posedge clk); #1;
        req_vld[idx] = 1'b0;
        wait_result(t1);
        chk("op_latency", t1 - t0, W + 1);
        chk("op_sum", res_sum, es);
        chk("op_id", res_id, eid);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("reset_res_vld", res_vld, 1'b0);
        chk("reset_res_sum", res_sum, '0);
        chk("reset_res_id", res_id, 1'b0);
        chk("reset_req_rdy", req_rdy, 2'b00);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1, prev;
        logic [W-1:0] exp_both [2];
        total   = 0;
        passed  = 0;
        rst     = 1'b0;
        req_vld = 2'b00;
        req_a   = '0;
        req_b   = '0;
        res_rdy = 1'b1;
        @(posedge clk); #1;
        do_reset(3);

        // Single requester, carry across the top bit, carry cleared for the next op.
        run_op(0, 8'h35, 8'h4A, 8'h7F, 1'b0);
        run_op(1, 8'hFF, 8'h01, 8'h00, 1'b1);
        run_op(1, 8'h01, 8'h01, 8'h02, 1'b1);

        // Both requesting from reset: grants alternate 0,1,0,1 at one op per W+2 cycles.
        do_reset(2);
        req_a[0] = 8'h10; req_b[0] = 8'h01;
        req_a[1] = 8'h20; req_b[1] = 8'h02;
        exp_both[0] = 8'h11;
        exp_both[1] = 8'h22;
        req_vld = 2'b11;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_result(t1);
            chk("rr_id", res_id, k % 2);
            chk("rr_sum", res_sum, exp_both[k % 2]);
            if (k > 0) chk("rr_period", t1 - prev, W + 2);
            prev = t1;
            @(posedge clk); #1;
            if (k == 3) req_vld = 2'b00;
        end

        // Consumer stalls five cycles; inputs churn and must be ignored.
        res_rdy  = 1'b0;
        req_a[0] = 8'hAA; req_b[0] = 8'h55;
        req_vld  = 2'b01;
        wait_grant(0, t0);
        @(posedge clk); #1;
        req_vld  = 2'b11;
        req_a[0] = 8'h00; req_b[0] = 8'h00;
        req_a[1] = 8'h77; req_b[1] = 8'h11;
        wait_result(t1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_res_vld", res_vld, 1'b1);
            chk("stall_res_sum", res_sum, 8'hFF);
            chk("stall_res_id", res_id, 1'b0);
            chk("stall_req_rdy", req_rdy, 2'b00);
            @(negedge clk);
        end
        @(posedge clk); #1;
        res_rdy = 1'b1;
        req_vld = 2'b00;
        @(posedge clk); #1;

        // Reset during shift bit 3 (carry pending) aborts the op silently.
        req_a[0] = 8'h0F; req_b[0] = 8'h0F;
        req_vld  = 2'b01;
        wait_grant(0, t0);
        @(posedge clk); #1;
        req_vld = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("abort_no_res_vld", res_vld, 1'b0);
        end
        @(posedge clk); #1;
        run_op(0, 8'h0F, 8'h01, 8'h10, 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_add_scheduler.md
SERIAL_ADD_SCHEDULER -- requirements
Module: serial_add_scheduler

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req_vld  input  2  per-requester operand valid; index 0 and 1.
REQ-005 SHALL have port: req_rdy  output  2  per-requester accept; transfer when req_vld[i] && req_rdy[i].
REQ-006 SHALL have port: req_a  input  2xWIDTH  per-requester operand A.
REQ-007 SHALL have port: req_b  input  2xWIDTH  per-requester operand B.
REQ-008 SHALL have port: res_vld  output  1  result valid.
REQ-009 SHALL have port: res_rdy  input  1  result consumer ready; transfer when res_vld && res_rdy.
REQ-010 SHALL have port: res_id  output  1  index of requester that owns the result.
REQ-011 SHALL have port: res_sum  output  WIDTH  (A + B) mod 2^WIDTH.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL, in IDLE only, assert req_rdy for exactly one requester with req_vld high; req_rdy SHALL be 0 in SHIFT and DONE.
REQ-014 SHALL arbitrate round-robin: single requester wins; both requesting, the requester indicated by priority pointer wins; pointer SHALL move to the other index after every grant.
REQ-015 SHALL, on grant at cycle T, capture operands and id, then go to SHIFT at T+1.
REQ-016 SHALL, in SHIFT cycle k (k = 0..WIDTH-1, starting T+1), drive adder vld=1, a=A[k], b=B[k], last=(k==WIDTH-1), LSB first.
REQ-017 SHALL capture adder sum bit into res_sum[k] in the same cycle k.
REQ-018 SHALL drive adder vld=0 and last=0 outside SHIFT.
REQ-019 SHALL enter DONE after k=WIDTH-1; res_vld SHALL rise at T+WIDTH+1.
REQ-020 SHALL hold res_vld, res_sum, res_id stable in DONE until res_rdy; on res_vld && res_rdy go to IDLE next cycle.
REQ-021 SHALL discard final carry-out; adder carry SHALL be zero at start of every operation (cleared by last).
REQ-022 SHALL ignore req_vld/req_a/req_b changes during SHIFT and DONE.
REQ-023 SHALL sustain one operation per WIDTH+2 cycles when res_rdy is held high.

Reset
REQ-024 SHALL, with rst low at posedge, set state=IDLE, pointer=0, res_vld=0, res_sum=0, res_id=0, internal shift registers=0.
REQ-025 SHALL hold req_rdy=0 and adder vld=0 while rst is low.
REQ-026 SHALL reset the adder carry in the same cycle as the scheduler.
REQ-027 SHALL abort an operation in progress on reset; no res_vld SHALL appear for it.

Structure
REQ-028 SHALL place FSM state enum typedef and requester count constant (2) in package serial_add_sched_pkg.
REQ-029 SHALL instantiate one sub-module serial_adder_with_vld (ports clk, rst active-high, vld, a, b, last, sum), driven with rst = ~rst of this block.
REQ-030 SHALL keep arbitration, FSM, bit counter and shift registers in this module; no other sub-modules.

Verification
REQ-031 SHALL cover: req0 only, A=8'h35 B=8'h4A, res_rdy=1 -> res_vld at T+9, res_sum=8'h7F, res_id=0.
REQ-032 SHALL cover: req1 A=8'hFF B=8'h01 -> res_sum=8'h00; next op A=8'h01 B=8'h01 -> res_sum=8'h02 (carry cleared).
REQ-033 SHALL cover: both req_vld held high from reset -> grants alternate 0,1,0,1; res_id sequence matches.
REQ-034 SHALL cover: res_rdy low 5 cycles in DONE -> res_vld, res_sum, res_id stable; req_rdy=00 throughout.
REQ-035 SHALL cover: rst low during SHIFT k=3 -> no res_vld; following op A=8'h0F B=8'h01 -> res_sum=8'h10.
REQ-036 SHALL cover: monitor adder ports -> vld high exactly WIDTH consecutive cycles per op, last high only on final one.
